// File: rtl/alu_cmd_master_if.sv
// Bundle of request, ALU-side and response signals for the ALU command master.
// The master modport is the initiator's view; slave is the source/ALU/consumer side.
interface alu_cmd_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OPC_W      = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OPC_W-1:0]      cmd_op;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  opcode_valid;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] data;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_timeout;
  logic                  err_spurious;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, done, result, overflow,
    output cmd_ready, opcode_valid, opcode, data,
           rsp_valid, rsp_result, rsp_overflow, rsp_timeout, err_spurious
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, done, result, overflow,
    input  cmd_ready, opcode_valid, opcode, data,
           rsp_valid, rsp_result, rsp_overflow, rsp_timeout, err_spurious
  );
endinterface

// File: rtl/alu_cmd_master.sv
// ALU command initiator: accepts one command, serializes the opcode LSB first with
// operands on the data bus, waits for done (or times out) and emits a one-cycle response.
module alu_cmd_master #(
  parameter int DATA_WIDTH = 8,
  parameter int OPC_W      = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_cmd_master_if.master  bus
);

  localparam int BCW = $clog2(OPC_W);
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(OPC_W - 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [OPC_W-1:0]      op_q, op_nxt;
  logic [DATA_WIDTH-1:0] a_q, a_nxt;
  logic [DATA_WIDTH-1:0] b_q, b_nxt;
  logic [BCW-1:0]        bit_cnt, bit_nxt, bit_inc;
  logic [WCW-1:0]        wait_cnt, wait_nxt;

  logic                  cmd_ready_nxt;
  logic                  opcode_valid_nxt;
  logic                  opcode_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_result_nxt;
  logic                  rsp_overflow_nxt;
  logic                  rsp_timeout_nxt;
  logic                  err_spurious_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      bit_cnt          <= '0;
      wait_cnt         <= '0;
      bus.cmd_ready    <= 1'b1;
      bus.opcode_valid <= 1'b0;
      bus.opcode       <= 1'b0;
      bus.data         <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_timeout  <= 1'b0;
      bus.err_spurious <= 1'b0;
    end else begin
      state            <= state_nxt;
      op_q             <= op_nxt;
      a_q              <= a_nxt;
      b_q              <= b_nxt;
      bit_cnt          <= bit_nxt;
      wait_cnt         <= wait_nxt;
      bus.cmd_ready    <= cmd_ready_nxt;
      bus.opcode_valid <= opcode_valid_nxt;
      bus.opcode       <= opcode_nxt;
      bus.data         <= data_nxt;
      bus.rsp_valid    <= rsp_valid_nxt;
      bus.rsp_result   <= rsp_result_nxt;
      bus.rsp_overflow <= rsp_overflow_nxt;
      bus.rsp_timeout  <= rsp_timeout_nxt;
      bus.err_spurious <= err_spurious_nxt;
    end
  end

  // Outputs are registered, so each branch computes what the next state must present.
  always_comb begin
    state_nxt        = state;
    op_nxt           = op_q;
    a_nxt            = a_q;
    b_nxt            = b_q;
    bit_nxt          = bit_cnt;
    wait_nxt         = wait_cnt;
    bit_inc          = bit_cnt + 1'b1;
    opcode_valid_nxt = 1'b0;
    opcode_nxt       = 1'b0;
    data_nxt         = '0;
    rsp_valid_nxt    = 1'b0;
    rsp_result_nxt   = bus.rsp_result;
    rsp_overflow_nxt = bus.rsp_overflow;
    rsp_timeout_nxt  = bus.rsp_timeout;
    err_spurious_nxt = bus.err_spurious | (bus.done && (state != WAIT));

    case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          op_nxt           = bus.cmd_op;
          a_nxt            = bus.cmd_a;
          b_nxt            = bus.cmd_b;
          bit_nxt          = '0;
          state_nxt        = SEND;
          opcode_valid_nxt = 1'b1;
          opcode_nxt       = bus.cmd_op[0];
          data_nxt         = bus.cmd_a;
        end
      end
      SEND: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = WAIT;
          wait_nxt  = '0;
        end else begin
          bit_nxt          = bit_inc;
          opcode_valid_nxt = 1'b1;
          opcode_nxt       = op_q[bit_inc];
          data_nxt         = (bit_inc == BCW'(1)) ? b_q : '0;
        end
      end
      WAIT: begin
        // done takes priority over the timeout boundary
        if (bus.done) begin
          state_nxt        = RESP;
          rsp_valid_nxt    = 1'b1;
          rsp_result_nxt   = bus.result;
          rsp_overflow_nxt = bus.overflow;
          rsp_timeout_nxt  = 1'b0;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nxt        = RESP;
          rsp_valid_nxt    = 1'b1;
          rsp_result_nxt   = '0;
          rsp_overflow_nxt = 1'b0;
          rsp_timeout_nxt  = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master: directed vector table, randomized commands
// against a cycle-count reference model, and hand-written reset/spurious/back-to-back cases.
module tb_alu_cmd_master;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int TO = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  alu_cmd_master_if #(.DATA_WIDTH(DW), .OPC_W(OW)) bus ();

  alu_cmd_master #(.DATA_WIDTH(DW), .OPC_W(OW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            lat;
    logic [DW-1:0] alu_res;
    logic          alu_ovf;
    logic [DW-1:0] exp_res;
    logic          exp_ovf;
    logic          exp_to;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU is an adder with carry as overflow; lat 0 or beyond TO means no done.
  function automatic vec_t model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input int lat);
    vec_t v;
    logic [DW:0] sum;
    sum       = {1'b0, a} + {1'b0, b};
    v.op      = op;
    v.a       = a;
    v.b       = b;
    v.lat     = lat;
    v.alu_res = sum[DW-1:0];
    v.alu_ovf = sum[DW];
    v.exp_to  = !(lat >= 1 && lat <= TO);
    v.exp_res = v.exp_to ? '0 : v.alu_res;
    v.exp_ovf = v.exp_to ? 1'b0 : v.alu_ovf;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v, input bit keep_valid, input vec_t nxt, output int waited);
    int            len;
    logic [DW-1:0] exp_data;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    while (bus.cmd_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check_output("accept_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    tick();
    if (keep_valid) begin
      bus.cmd_op = nxt.op;
      bus.cmd_a  = nxt.a;
      bus.cmd_b  = nxt.b;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int j = 1; j <= OW; j++) begin
      exp_data = (j == 1) ? v.a : (j == 2) ? v.b : '0;
      check_output("send_valid", 32'(bus.opcode_valid), 32'd1);
      check_output("send_bit", 32'(bus.opcode), 32'((int'(v.op) >> (j - 1)) & 1));
      check_output("send_data", 32'(bus.data), 32'(exp_data));
      check_output("send_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    len = v.exp_to ? TO : v.lat;
    for (int w = 1; w <= len; w++) begin
      check_output("wait_valid", 32'(bus.opcode_valid), 32'd0);
      check_output("wait_data", 32'(bus.data), 32'd0);
      check_output("wait_opcode", 32'(bus.opcode), 32'd0);
      check_output("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      if (w == v.lat) begin
        bus.done     = 1'b1;
        bus.result   = v.alu_res;
        bus.overflow = v.alu_ovf;
      end
      tick();
      bus.done     = 1'b0;
      bus.result   = DW'($urandom);
      bus.overflow = 1'b0;
    end
    check_output("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("rsp_result", 32'(bus.rsp_result), 32'(v.exp_res));
    check_output("rsp_overflow", 32'(bus.rsp_overflow), 32'(v.exp_ovf));
    check_output("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
    check_output("rsp_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    check_output("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    check_output("ready_after", 32'(bus.cmd_ready), 32'd1);
    check_output("idle_valid", 32'(bus.opcode_valid), 32'd0);
    check_output("hold_result", 32'(bus.rsp_result), 32'(v.exp_res));
    check_output("hold_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
  endtask

  initial begin
    vec_t tbl [6];
    vec_t v1, v2;
    int   waited;
    int   guard;
    logic seen;

    tbl[0] = '{3'b101, 8'h12, 8'h34, 2,  8'h46, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[1] = '{3'b011, 8'hF0, 8'h20, 1,  8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
    tbl[2] = '{3'b110, 8'h55, 8'hAA, 0,  8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{3'b001, 8'h01, 8'h02, 16, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{3'b111, 8'h80, 8'h80, 15, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{3'b010, 8'h7F, 8'h01, 17, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.done      = 1'b0;
    bus.result    = '0;
    bus.overflow  = 1'b0;

    #12;
    check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("reset_opcode_valid", 32'(bus.opcode_valid), 32'd0);
    check_output("reset_opcode", 32'(bus.opcode), 32'd0);
    check_output("reset_data", 32'(bus.data), 32'd0);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    check_output("reset_rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
    check_output("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check_output("reset_err_spurious", 32'(bus.err_spurious), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) apply_stimulus(tbl[i], 1'b0, tbl[i], waited);
    check_output("no_spurious_yet", 32'(bus.err_spurious), 32'd0);

    $display("[TB] random commands");
    for (int i = 0; i < 30; i++) begin
      v1 = model(OW'($urandom), DW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 2)));
      apply_stimulus(v1, 1'b0, v1, waited);
    end

    $display("[TB] back-to-back");
    v1 = model(3'b100, 8'hA5, 8'h5A, 3);
    v2 = model(3'b011, 8'h33, 8'h44, 1);
    apply_stimulus(v1, 1'b1, v2, waited);
    apply_stimulus(v2, 1'b0, v2, waited);
    check_output("b2b_accept_wait", 32'(waited), 32'd0);

    $display("[TB] spurious done");
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_output("spurious_set", 32'(bus.err_spurious), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | bus.rsp_valid;
      tick();
    end
    check_output("spurious_no_rsp", 32'(seen), 32'd0);
    check_output("spurious_sticky", 32'(bus.err_spurious), 32'd1);
    v1 = model(3'b001, 8'h10, 8'h20, 2);
    apply_stimulus(v1, 1'b0, v1, waited);
    check_output("spurious_sticky_after_cmd", 32'(bus.err_spurious), 32'd1);

    $display("[TB] reset mid-command");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b110;
    bus.cmd_a     = 8'h3C;
    bus.cmd_b     = 8'hC3;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    check_output("midreset_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check_output("midreset_in_send", 32'(bus.data), 32'hC3);
    reset_n = 1'b0;
    #1;
    check_output("midreset_opcode_valid", 32'(bus.opcode_valid), 32'd0);
    check_output("midreset_data", 32'(bus.data), 32'd0);
    check_output("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("midreset_err_cleared", 32'(bus.err_spurious), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen = seen | bus.rsp_valid | bus.opcode_valid;
      tick();
    end
    check_output("midreset_no_rsp", 32'(seen), 32'd0);
    v1 = model(3'b101, 8'h12, 8'h34, 2);
    apply_stimulus(v1, 1'b0, v1, waited);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
